// File: rtl/image_decimator_if.sv
// Command/data bus of image_decimator: 2-bit status command, load/read address and data,
// plus the busy/end_process/readback results.
interface image_decimator_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic [1:0]        status;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              end_process;
    logic              busy;
    logic [DATA_W-1:0] out;

    modport master (
        output status, data, addr,
        input  end_process, busy, out
    );

    modport slave (
        input  status, data, addr,
        output end_process, busy, out
    );
endinterface

// File: rtl/image_decimator.sv
// Frame buffer + 3x3 binomial smoothing at stride 2 into an addressed output buffer.
// Optional macro ROUND_EN: round-half-up result instead of truncation.
module image_decimator #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    image_decimator_if.slave bus
);

    localparam int OUT_W  = (IMG_W - 3) / 2 + 1;
    localparam int OUT_H  = (IMG_H - 3) / 2 + 1;
    localparam int IN_N   = IMG_W * IMG_H;
    localparam int OUT_N  = OUT_W * OUT_H;
    localparam int IN_AW  = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int OUT_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int ACC_W  = DATA_W + 4;

    localparam logic [ADDR_W:0]   C_IN_N     = (ADDR_W + 1)'(IN_N);
    localparam logic [ADDR_W:0]   C_OUT_N    = (ADDR_W + 1)'(OUT_N);
    localparam logic [ADDR_W-1:0] C_ROW_STEP = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] C_TWO_ROWS = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] C_LAST_COL = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] C_LAST_PIX = ADDR_W'(OUT_N - 1);
    localparam logic [ADDR_W-1:0] C_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_TWO      = ADDR_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PROC,
        S_DONE,
        S_READ
    } state_t;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_PROC = 2'b01;
    localparam logic [1:0] CMD_LOAD = 2'b10;
    localparam logic [1:0] CMD_READ = 2'b11;

    state_t r_state;
    state_t w_next_state;

    logic [1:0] r_prev_status;
    logic       r_prev_valid;
    logic       r_hold;
    logic       w_status_changed;
    logic       w_hold_active;

    logic [3:0]        r_tap;
    logic [1:0]        r_kx;
    logic [1:0]        r_ky;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_out_idx;
    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_rd_data;
    logic [1:0]        r_rd_shift;

    logic [ACC_W-1:0]  w_acc_sum;
    logic [ACC_W-1:0]  w_rounded;
    logic [DATA_W-1:0] w_pix_value;
    logic              w_tap_read;
    logic              w_pix_write;
    logic              w_last_pix;
    logic              w_load_wr;
    logic              w_read_ok;

    logic              r_end_process;
    logic [DATA_W-1:0] r_out;

    logic [DATA_W-1:0] in_buf  [IN_N];
    logic [DATA_W-1:0] out_buf [OUT_N];

    // After reset the held command is ignored until it changes, so a reset
    // mid-process cannot silently restart processing.
    assign w_status_changed = r_prev_valid && (bus.status != r_prev_status);
    assign w_hold_active    = r_hold && !w_status_changed;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_status <= CMD_IDLE;
            r_prev_valid  <= 1'b0;
            r_hold        <= 1'b1;
        end else begin
            r_prev_status <= bus.status;
            r_prev_valid  <= 1'b1;
            if (w_status_changed) begin
                r_hold <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state gets a default before any branch, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (w_hold_active) begin
            w_next_state = S_IDLE;
        end else begin
            case (bus.status)
                CMD_IDLE: w_next_state = S_IDLE;
                CMD_LOAD: w_next_state = S_LOAD;
                CMD_READ: w_next_state = S_READ;
                default: begin
                    case (r_state)
                        S_PROC:  w_next_state = w_last_pix ? S_DONE : S_PROC;
                        S_DONE:  w_next_state = S_DONE;
                        default: w_next_state = (r_prev_status != CMD_PROC) ? S_PROC : S_IDLE;
                    endcase
                end
            endcase
        end
    end

    // Ten cycles per output pixel: taps 0..8 issue reads, tap 9 folds in the last tap and writes.
    assign w_tap_read  = (r_state == S_PROC) && (r_tap != 4'd9);
    assign w_pix_write = (r_state == S_PROC) && (r_tap == 4'd9);
    assign w_last_pix  = w_pix_write && (r_out_idx == C_LAST_PIX);
    assign w_acc_sum   = r_acc + (ACC_W'(r_rd_data) << r_rd_shift);

`ifdef ROUND_EN
    assign w_rounded = w_acc_sum + ACC_W'(8);
`else
    assign w_rounded = w_acc_sum;
`endif
    assign w_pix_value = DATA_W'(w_rounded >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap      <= 4'd0;
            r_kx       <= 2'd0;
            r_ky       <= 2'd0;
            r_rd_addr  <= '0;
            r_base     <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_out_idx  <= '0;
            r_acc      <= '0;
            r_rd_shift <= 2'd0;
        end else if (r_state != S_PROC) begin
            r_tap      <= 4'd0;
            r_kx       <= 2'd0;
            r_ky       <= 2'd0;
            r_rd_addr  <= '0;
            r_base     <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_out_idx  <= '0;
            r_acc      <= '0;
            r_rd_shift <= 2'd0;
        end else if (w_pix_write) begin
            r_tap     <= 4'd0;
            r_kx      <= 2'd0;
            r_ky      <= 2'd0;
            r_acc     <= '0;
            r_out_idx <= r_out_idx + C_ONE;
            if (r_col == C_LAST_COL) begin
                r_col      <= '0;
                r_row_base <= r_row_base + C_TWO_ROWS;
                r_base     <= r_row_base + C_TWO_ROWS;
                r_rd_addr  <= r_row_base + C_TWO_ROWS;
            end else begin
                r_col     <= r_col + C_ONE;
                r_base    <= r_base + C_TWO;
                r_rd_addr <= r_base + C_TWO;
            end
        end else begin
            r_tap      <= r_tap + 4'd1;
            // Centre row/column each double the weight: 1, 2 or 4 as a shift.
            r_rd_shift <= {1'b0, (r_kx == 2'd1)} + {1'b0, (r_ky == 2'd1)};
            if (r_tap != 4'd0) begin
                r_acc <= w_acc_sum;
            end
            if (r_kx == 2'd2) begin
                r_kx      <= 2'd0;
                r_ky      <= r_ky + 2'd1;
                r_rd_addr <= r_rd_addr + C_ROW_STEP;
            end else begin
                r_kx      <= r_kx + 2'd1;
                r_rd_addr <= r_rd_addr + C_ONE;
            end
        end
    end

    assign w_load_wr = (w_next_state == S_LOAD) && ({1'b0, bus.addr} < C_IN_N);
    assign w_read_ok = {1'b0, bus.addr} < C_OUT_N;

    // NOTE: frame buffers are plain RAM with no reset; their contents are
    // only meaningful once loaded or processed.
    always_ff @(posedge clk) begin
        if (w_load_wr) begin
            in_buf[IN_AW'(bus.addr)] <= bus.data;
        end
        if (w_tap_read) begin
            r_rd_data <= in_buf[IN_AW'(r_rd_addr)];
        end
        if (w_pix_write) begin
            out_buf[OUT_AW'(r_out_idx)] <= w_pix_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_next_state == S_READ) begin
            r_out <= w_read_ok ? out_buf[OUT_AW'(bus.addr)] : '0;
        end
    end

    // Completion flag lags the PROC->DONE edge by one cycle and drops with the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_end_process <= 1'b0;
        end else begin
            r_end_process <= (r_state == S_DONE) && (w_next_state == S_DONE);
        end
    end

    assign bus.busy        = (r_state == S_PROC);
    assign bus.end_process = r_end_process;
    assign bus.out         = r_out;

endmodule

// File: tb/tb_image_decimator.sv
// Scoreboard bench for image_decimator on a 9x7 frame (4x3 output): ramp, flat,
// impulse, abort/restart, reset mid-process and out-of-range load.
module tb_image_decimator;

    localparam int IMG_W  = 9;
    localparam int IMG_H  = 7;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int OUT_W  = 4;
    localparam int IN_N   = 63;
    localparam int OUT_N  = 12;
    localparam int PROC_CYCLES = 10 * OUT_N + 1;

    typedef struct {
        int addr;
        int val;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    image_decimator_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    image_decimator #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int       n_checks = 0;
    int       n_fail   = 0;
    int       img     [IN_N];
    int       exp_out [OUT_N];
    sb_item_t sb_q    [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int kernel(input int r, input int c);
        int acc = 0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                acc += ((ky == 1) ? 2 : 1) * ((kx == 1) ? 2 : 1) * img[(2 * r + ky) * IMG_W + 2 * c + kx];
            end
        end
`ifdef ROUND_EN
        return (acc + 8) >> 4;
`else
        return acc >> 4;
`endif
    endfunction

    task automatic model_process(input int n_pix);
        for (int p = 0; p < n_pix; p++) begin
            exp_out[p] = kernel(p / OUT_W, p % OUT_W);
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < IN_N; i++) begin
            bus.status = 2'b10;
            bus.addr   = ADDR_W'(i);
            bus.data   = DATA_W'(img[i]);
            tick();
        end
        bus.status = 2'b00;
        tick();
    endtask

    task automatic read_range(input int lo, input int hi);
        sb_item_t it;
        for (int a = lo; a <= hi; a++) begin
            bus.status = 2'b11;
            bus.addr   = ADDR_W'(a);
            it.addr    = a;
            it.val     = (a < OUT_N) ? exp_out[a] : 0;
            sb_q.push_back(it);
            tick();
            it = sb_q.pop_front();
            check($sformatf("rd_addr%0d", it.addr), 32'(bus.out), it.val);
        end
        bus.status = 2'b00;
        tick();
    endtask

    task automatic run_proc(input string tag);
        int k;
        bus.status = 2'b01;
        tick();
        check({tag, "_busy_rise"}, 32'(bus.busy), 1);
        for (k = 1; k <= 4 * PROC_CYCLES; k++) begin
            tick();
            if (bus.end_process) break;
        end
        check({tag, "_end_cycles"}, k, PROC_CYCLES);
        check({tag, "_busy_done"}, 32'(bus.busy), 0);
        model_process(OUT_N);
        repeat (3) tick();
        check({tag, "_end_hold"}, 32'(bus.end_process), 1);
        bus.status = 2'b00;
        tick();
        check({tag, "_end_drop"}, 32'(bus.end_process), 0);
    endtask

    initial begin
        int busy_seen;
        rst_n      = 1'b0;
        bus.status = 2'b00;
        bus.addr   = '0;
        bus.data   = '0;
        #12;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_end", 32'(bus.end_process), 0);
        check("rst_out", 32'(bus.out), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Ramp frame: out(0,0) = (16*10)>>4 = 10.
        for (int i = 0; i < IN_N; i++) img[i] = i;
        load_frame();
        run_proc("ramp");
        read_range(0, OUT_N + 3);

        read_range(5, 5);
        bus.addr = ADDR_W'(0);
        repeat (2) tick();
        check("out_hold", 32'(bus.out), exp_out[5]);

        // Flat frame, aborted after four pixels have been written.
        for (int i = 0; i < IN_N; i++) img[i] = 128;
        load_frame();
        bus.status = 2'b01;
        tick();
        repeat (44) tick();
        bus.status = 2'b00;
        tick();
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_end", 32'(bus.end_process), 0);
        model_process(4);
        read_range(0, 3);
        read_range(OUT_N - 1, OUT_N - 1);
        run_proc("flat");
        read_range(0, OUT_N - 1);

        // Impulse, then an out-of-range write that must not land anywhere.
        for (int i = 0; i < IN_N; i++) img[i] = 0;
        img[2 * IMG_W + 2] = 255;
        load_frame();
        bus.status = 2'b10;
        bus.addr   = 16'hFFFF;
        bus.data   = 8'h77;
        tick();
        bus.status = 2'b00;
        tick();
        run_proc("impulse");
        read_range(0, OUT_N - 1);

        // Reset mid-process; the held 01 must not restart processing.
        bus.status = 2'b01;
        tick();
        repeat (29) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_end", 32'(bus.end_process), 0);
        check("midrst_out", 32'(bus.out), 0);
        #2;
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy || bus.end_process) busy_seen++;
        end
        check("midrst_no_restart", busy_seen, 0);
        bus.status = 2'b00;
        tick();
        run_proc("rerun");
        read_range(0, OUT_N);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
